// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO that feeds a uart_tx one launch per completed byte
// Writes while full are dropped and latched in a sticky overflow flag.
module uart_tx_fifo #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk48,
  input  logic          rst,
  input  logic [7:0]    din,
  input  logic          din_v,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          tx_dv,
  output logic [7:0]    tx_byte,
  input  logic          tx_busy,
  input  logic          tx_done
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt_q;
  state_t        state;
  logic          push;
  logic          pop;

  assign count = cnt_q;
  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);

  // Both decisions use the registered count, so a pop never frees room for a same-cycle push.
  assign push = din_v & ~full;
  assign pop  = (state == IDLE) & ~empty & ~tx_busy;

  always_ff @(posedge clk48) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk48) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt_q    <= '0;
      overflow <= 1'b0;
      tx_dv    <= 1'b0;
      tx_byte  <= 8'h00;
      state    <= IDLE;
    end else begin
      tx_dv <= 1'b0;

      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (din_v && full) begin
        overflow <= 1'b1;
      end

      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase

      case (state)
        IDLE: begin
          if (pop) begin
            tx_dv   <= 1'b1;
            tx_byte <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + PTR_ONE;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (tx_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo (64-deep and 4-deep instances)
module tb_uart_tx_fifo;

  logic clk48 = 1'b0;
  always #5 clk48 = ~clk48;

  int tests = 0;
  int fails = 0;

  // 64-deep instance
  logic       rst, din_v, full, empty, overflow, tx_dv, tx_busy, tx_done;
  logic [7:0] din, tx_byte;
  logic [6:0] count;
  logic       uart_en, man_busy, man_done, model_busy, model_done;
  int         uart_clks = 417;

  assign tx_busy = uart_en ? model_busy : man_busy;
  assign tx_done = uart_en ? model_done : man_done;

  uart_tx_fifo #(.DEPTH(64), .AW(6)) u_dut (
    .clk48(clk48), .rst(rst), .din(din), .din_v(din_v), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .tx_dv(tx_dv), .tx_byte(tx_byte),
    .tx_busy(tx_busy), .tx_done(tx_done)
  );

  // 4-deep instance
  logic       s_rst, s_din_v, s_full, s_empty, s_overflow, s_tx_dv, s_busy, s_done;
  logic [7:0] s_din, s_tx_byte;
  logic [2:0] s_count;

  uart_tx_fifo #(.DEPTH(4), .AW(2)) u_small (
    .clk48(clk48), .rst(s_rst), .din(s_din), .din_v(s_din_v), .full(s_full), .empty(s_empty),
    .count(s_count), .overflow(s_overflow), .tx_dv(s_tx_dv), .tx_byte(s_tx_byte),
    .tx_busy(s_busy), .tx_done(s_done)
  );

  logic [7:0] exp_q[$];
  logic [7:0] exp_s[$];
  int dv_cnt = 0;
  int s_dv_cnt = 0;
  int max_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk48) begin : mon_main
    logic [7:0] e;
    if (tx_dv) begin
      dv_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL main_unexpected_dv: got %0h expected no launch", tx_byte);
      end else begin
        e = exp_q.pop_front();
        check("main_byte_order", tx_byte, e);
      end
    end
    if (int'(count) > max_cnt) max_cnt = int'(count);
  end

  always @(negedge clk48) begin : mon_small
    logic [7:0] e;
    if (s_tx_dv) begin
      s_dv_cnt++;
      if (exp_s.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL small_unexpected_dv: got %0h expected no launch", s_tx_byte);
      end else begin
        e = exp_s.pop_front();
        check("small_byte_order", s_tx_byte, e);
      end
    end
  end

  // uart_tx stand-in: busy for uart_clks cycles after each launch, then a one-cycle done
  initial begin
    model_busy = 1'b0;
    model_done = 1'b0;
    forever begin
      @(negedge clk48);
      if (uart_en && tx_dv) begin
        model_busy = 1'b1;
        repeat (uart_clks - 1) @(negedge clk48);
        model_done = 1'b1;
        @(negedge clk48);
        model_done = 1'b0;
        model_busy = 1'b0;
      end
    end
  end

  task automatic push_main(input logic [7:0] b, input bit kept);
    din   = b;
    din_v = 1'b1;
    if (kept) exp_q.push_back(b);
    @(negedge clk48);
    din_v = 1'b0;
  endtask

  task automatic wait_dv(input int target, input int budget, input string name);
    int k = 0;
    while (dv_cnt < target && k < budget) begin
      @(negedge clk48);
      k++;
    end
    check(name, dv_cnt, target);
  endtask

  task automatic small_drain(input int n);
    for (int i = 0; i < n; i++) begin
      int k = 0;
      while (!s_tx_dv && k < 20) begin
        @(negedge clk48);
        k++;
      end
      check("small_launch_seen", s_tx_dv, 1'b1);
      @(negedge clk48);
      s_done = 1'b1;
      @(negedge clk48);
      s_done = 1'b0;
    end
  endtask

  initial begin
    int base;
    rst = 1'b1; din = 8'h00; din_v = 1'b0;
    uart_en = 1'b0; man_busy = 1'b0; man_done = 1'b0;
    s_rst = 1'b1; s_din = 8'h00; s_din_v = 1'b0; s_busy = 1'b0; s_done = 1'b0;
    repeat (3) @(negedge clk48);
    rst = 1'b0;
    s_rst = 1'b0;
    @(negedge clk48);

    check("reset_count", count, 7'd0);
    check("reset_empty", empty, 1'b1);
    check("reset_full", full, 1'b0);
    check("reset_overflow", overflow, 1'b0);
    check("reset_tx_dv", tx_dv, 1'b0);
    check("reset_tx_byte", tx_byte, 8'h00);

    // Single byte: launch on the second cycle after the write, then hold until tx_done
    push_main(8'h41, 1'b1);
    check("single_count_after_write", count, 7'd1);
    @(negedge clk48);
    check("single_tx_dv", tx_dv, 1'b1);
    check("single_tx_byte", tx_byte, 8'h41);
    check("single_count_after_launch", count, 7'd0);
    repeat (10) @(negedge clk48);
    check("single_no_relaunch", dv_cnt, 1);
    check("single_tx_byte_held", tx_byte, 8'h41);
    man_done = 1'b1;
    @(negedge clk48);
    man_done = 1'b0;
    repeat (5) @(negedge clk48);
    check("single_done_no_launch", dv_cnt, 1);

    // Reset while waiting on the uart with three bytes queued
    base = dv_cnt;
    for (int i = 0; i < 4; i++) push_main(8'hB0 + 8'(i), i == 0);
    check("rstwait_queued", count, 7'd3);
    check("rstwait_one_launch", dv_cnt, base + 1);
    rst = 1'b1;
    @(negedge clk48);
    rst = 1'b0;
    check("rstwait_count", count, 7'd0);
    check("rstwait_empty", empty, 1'b1);
    check("rstwait_tx_dv", tx_dv, 1'b0);
    man_done = 1'b1;
    @(negedge clk48);
    man_done = 1'b0;
    repeat (5) @(negedge clk48);
    check("rstwait_done_ignored", dv_cnt, base + 1);

    // Ten back-to-back bytes against a 417-clock uart
    uart_clks = 417;
    uart_en = 1'b1;
    base = dv_cnt;
    for (int i = 0; i < 10; i++) push_main(8'(i), 1'b1);
    wait_dv(base + 10, 5000, "burst10_launches");
    repeat (430) @(negedge clk48);
    check("burst10_overflow", overflow, 1'b0);
    check("burst10_count", count, 7'd0);
    check("burst10_launch_total", dv_cnt, base + 10);

    // 2*DEPTH+3 bytes while draining: both pointers wrap twice
    uart_clks = 3;
    max_cnt = 0;
    base = dv_cnt;
    for (int i = 0; i < 70; i++) push_main(8'(i + 16), 1'b1);
    for (int i = 70; i < 131; i++) begin
      push_main(8'(i + 16), 1'b1);
      repeat (5) @(negedge clk48);
    end
    wait_dv(base + 131, 3000, "wrap_launches");
    repeat (10) @(negedge clk48);
    check("wrap_overflow", overflow, 1'b0);
    check("wrap_count", count, 7'd0);
    check("wrap_max_count_le_depth", max_cnt <= 64, 1'b1);
    uart_en = 1'b0;

    // 4-deep, uart stalled: six writes, last two dropped
    s_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_din = 8'hA0 + 8'(i);
      s_din_v = 1'b1;
      if (i < 4) exp_s.push_back(s_din);
      @(negedge clk48);
      if (i == 2) check("small_not_full_at_3", s_full, 1'b0);
      if (i == 3) check("small_full_at_4", s_full, 1'b1);
    end
    s_din_v = 1'b0;
    check("small_overflow_set", s_overflow, 1'b1);
    check("small_count_capped", s_count, 3'd4);
    check("small_no_launch_stalled", s_dv_cnt, 0);
    s_busy = 1'b0;
    small_drain(4);
    repeat (5) @(negedge clk48);
    check("small_drained_empty", s_empty, 1'b1);
    check("small_overflow_sticky", s_overflow, 1'b1);
    check("small_launch_total", s_dv_cnt, 4);

    // Full FIFO: push and launch in the same cycle, push is dropped
    s_rst = 1'b1;
    @(negedge clk48);
    s_rst = 1'b0;
    check("small_rst_overflow", s_overflow, 1'b0);
    s_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_din = 8'hC0 + 8'(i);
      s_din_v = 1'b1;
      exp_s.push_back(s_din);
      @(negedge clk48);
    end
    check("small_full_before_race", s_full, 1'b1);
    s_busy = 1'b0;
    s_din = 8'hC4;
    s_din_v = 1'b1;
    @(negedge clk48);
    s_din_v = 1'b0;
    check("race_count", s_count, 3'd3);
    check("race_overflow", s_overflow, 1'b1);
    check("race_launch", s_tx_dv, 1'b1);
    small_drain(4);
    repeat (5) @(negedge clk48);
    check("race_drained_empty", s_empty, 1'b1);

    check("main_queue_empty", exp_q.size(), 0);
    check("small_queue_empty", exp_s.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning byte capacity; power of two, 4..1024.
REQ-002 SHALL have parameter AW, default 6, meaning pointer width; equals log2(DEPTH).
REQ-003 SHALL have port clk48  input  1  system clock (48 MHz); all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port din  input  8  byte from the producer (status annunciator).
REQ-006 SHALL have port din_v  input  1  one-cycle write strobe for din.
REQ-007 SHALL have port full  output  1  high when count == DEPTH.
REQ-008 SHALL have port empty  output  1  high when count == 0.
REQ-009 SHALL have port count  output  AW+1  number of bytes stored.
REQ-010 SHALL have port overflow  output  1  sticky flag; a write was dropped.
REQ-011 SHALL have port tx_dv  output  1  one-cycle launch strobe to uart_tx i_TX_DV.
REQ-012 SHALL have port tx_byte  output  8  byte to uart_tx i_TX_Byte.
REQ-013 SHALL have port tx_busy  input  1  uart_tx o_TX_Active.
REQ-014 SHALL have port tx_done  input  1  uart_tx o_TX_Done, one-cycle pulse per byte.

Function
REQ-015 SHALL store bytes in a DEPTH x 8 circular buffer; wr_ptr and rd_ptr are AW bits and wrap from DEPTH-1 to 0.
REQ-016 SHALL accept din on any cycle with din_v high and full low; the byte is written at wr_ptr, and wr_ptr then increments.
REQ-017 SHALL drop din when din_v is high and full is high, leave the pointers and count unchanged, and set overflow to 1 on the next edge.
REQ-018 SHALL hold overflow at 1 until rst; it is not cleared by draining.
REQ-019 SHALL evaluate full from the registered count at cycle start, so a write while full is dropped even if a pop occurs in the same cycle.
REQ-020 SHALL implement the FSM states IDLE and WAIT; the reset state is IDLE.
REQ-021 IDLE -> WAIT SHALL occur when empty == 0 and tx_busy == 0: on that edge tx_dv <= 1, tx_byte <= mem[rd_ptr], rd_ptr increments, and count decrements.
REQ-022 SHALL assert tx_dv for exactly one cycle per launch; tx_byte SHALL hold its value until the next launch.
REQ-023 WAIT -> IDLE SHALL occur on the edge where tx_done == 1; a new launch can occur no earlier than the following edge.
REQ-024 SHALL ignore tx_done in IDLE; it SHALL cause no state change or pointer change.
REQ-025 SHALL apply count += 1 for a push, -= 1 for a pop, and stay unchanged when a push and a pop occur in the same cycle.
REQ-026 Latency: a byte written into an empty FIFO with the state in IDLE and tx_busy low SHALL appear as tx_dv = 1 in the second cycle after the din_v cycle.
REQ-027 SHALL transmit bytes in write order with no duplication or loss, except for bytes dropped under REQ-017.
REQ-028 SHALL drive full, empty and count combinationally from the registered count only.

Reset
REQ-029 On rst = 1 at a clock edge, SHALL set wr_ptr = 0, rd_ptr = 0, count = 0, overflow = 0, tx_dv = 0, tx_byte = 8'h00, and state = IDLE.
REQ-030 SHALL treat reset mid-transfer (state WAIT) as discarding all stored bytes and returning to IDLE; a later tx_done SHALL be ignored per REQ-024.
REQ-031 SHALL not initialise buffer contents on reset; bytes become readable only after being written.

Verification
REQ-032 Push 8'h41 into the empty FIFO with tx_busy = 0 -> tx_dv = 1 and tx_byte = 8'h41 two cycles later; count returns to 0; no second tx_dv until tx_done is pulsed.
REQ-033 Push 8'h00..8'h09 back to back with uart_tx modelled at 417 clocks per byte -> exactly ten tx_dv pulses carrying 00..09 in order; overflow stays 0.
REQ-034 With DEPTH = 4 and uart stalled, push 6 bytes A0..A5 -> full = 1 after the 4th byte; overflow = 1; the output sequence is A0..A3; overflow stays 1 after empty.
REQ-035 At count = DEPTH, push and launch in the same cycle -> the pushed byte is dropped, count = DEPTH-1, and overflow = 1.
REQ-036 Assert rst for 1 cycle while in WAIT with 3 bytes queued -> count = 0, empty = 1, tx_dv = 0; a tx_done pulse after reset produces no tx_dv.
REQ-037 Push 2*DEPTH+3 bytes while draining -> pointers wrap, the data order is preserved, and count never exceeds DEPTH.
